// File: rtl/acumulador_pkg.sv
// Shared constants for the selective accumulator: operation select codes and counter width.
package acumulador_pkg;

  localparam logic [1:0] SEL_DATA2 = 2'b00;
  localparam logic [1:0] SEL_SUMA  = 2'b01;
  localparam logic [1:0] SEL_DATA1 = 2'b10;
  localparam logic [1:0] SEL_ACC   = 2'b11;

  localparam int NB_COUNT = 8;

endpackage

// File: rtl/selector_suma.sv
// Combinational operation unit: picks data2, sum, data1 or base+sum and flags accumulate carry.
module selector_suma
  import acumulador_pkg::*;
#(
  parameter int NB_DATA = 3,
  parameter int NB_ACC  = 6,
  parameter bit SAT_EN  = 1'b0
) (
  input  logic [NB_DATA-1:0] i_data1,
  input  logic [NB_DATA-1:0] i_data2,
  input  logic [1:0]         i_sel,
  input  logic [NB_ACC-1:0]  i_base,
  output logic [NB_ACC-1:0]  o_res,
  output logic               o_ovf
);

  logic [NB_ACC-1:0] data1Ext;
  logic [NB_ACC-1:0] data2Ext;
  logic [NB_ACC-1:0] sum;
  logic [NB_ACC:0]   accWide;

  assign data1Ext = {{(NB_ACC-NB_DATA){1'b0}}, i_data1};
  assign data2Ext = {{(NB_ACC-NB_DATA){1'b0}}, i_data2};
  // NB_ACC is at least one bit wider than the operands, so this sum cannot carry out.
  assign sum      = data1Ext + data2Ext;
  assign accWide  = {1'b0, i_base} + {1'b0, sum};

  always_comb begin
    o_res = sum;
    o_ovf = 1'b0;
    case (i_sel)
      SEL_DATA2: o_res = data2Ext;
      SEL_SUMA:  o_res = sum;
      SEL_DATA1: o_res = data1Ext;
      default: begin
        o_ovf = accWide[NB_ACC];
        if (SAT_EN && accWide[NB_ACC]) o_res = {NB_ACC{1'b1}};
        else                           o_res = accWide[NB_ACC-1:0];
      end
    endcase
  end

endmodule

// File: rtl/acumulador_selectivo.sv
// Registered selective accumulator with valid/ready on both sides, sticky overflow and accept counter.
// Define ACUMULADOR_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module acumulador_selectivo
  import acumulador_pkg::*;
#(
  parameter int NB_DATA = 3,
  parameter int NB_ACC  = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NB_DATA-1:0]  i_data1,
  input  logic [NB_DATA-1:0]  i_data2,
  input  logic [1:0]          i_sel,
  input  logic                i_clr,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [NB_ACC-1:0]   o_suma,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_ovf,
  output logic [NB_COUNT-1:0] o_count
);

`ifdef ACUMULADOR_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic [NB_ACC-1:0]   suma_q, suma_d;
  logic [NB_ACC-1:0]   acc_q, acc_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;
  logic [NB_COUNT-1:0] count_q, count_d;

  logic              accept;
  logic              handoff;
  logic [NB_ACC-1:0] base;
  logic [NB_ACC-1:0] res;
  logic              resOvf;

  assign o_ready = !valid_q || i_ready;
  assign accept  = i_valid && o_ready;
  assign handoff = valid_q && i_ready;
  assign base    = i_clr ? '0 : acc_q;

  selector_suma #(
    .NB_DATA(NB_DATA),
    .NB_ACC (NB_ACC),
    .SAT_EN (SatEn)
  ) u_selector (
    .i_data1(i_data1),
    .i_data2(i_data2),
    .i_sel  (i_sel),
    .i_base (base),
    .o_res  (res),
    .o_ovf  (resOvf)
  );

  // A clear restarts the sticky flag from this transaction's own overflow.
  always_comb begin
    suma_d  = suma_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    if (accept) begin
      suma_d  = res;
      valid_d = 1'b1;
      acc_d   = (i_sel == SEL_ACC) ? res : base;
      ovf_d   = i_clr ? resOvf : (ovf_q | resOvf);
      count_d = count_q + NB_COUNT'(1);
    end else if (handoff) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      suma_q  <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      suma_q  <= suma_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign o_suma  = suma_q;
  assign o_valid = valid_q;
  assign o_ovf   = ovf_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_acumulador_selectivo.sv
// Self-checking bench for acumulador_selectivo (NB_DATA=3, NB_ACC=6); honours ACUMULADOR_SAT_EN.
module tb_acumulador_selectivo;

  localparam int NB_DATA = 3;
  localparam int NB_ACC  = 6;
  localparam int NVEC    = 16;

  typedef struct {
    logic [1:0]         sel;
    logic [NB_DATA-1:0] d1;
    logic [NB_DATA-1:0] d2;
    logic               clr;
    logic [NB_ACC-1:0]  expSuma;
    logic               expOvf;
  } vec_t;

  logic               clock;
  logic               reset;
  logic [NB_DATA-1:0] data1;
  logic [NB_DATA-1:0] data2;
  logic [1:0]         sel;
  logic               clr;
  logic               validIn;
  logic               readyOut;
  logic [NB_ACC-1:0]  suma;
  logic               validOut;
  logic               readyIn;
  logic               ovf;
  logic [7:0]         count;

  int   checks;
  int   errors;
  vec_t vecs [NVEC];

  acumulador_selectivo #(
    .NB_DATA(NB_DATA),
    .NB_ACC (NB_ACC)
  ) dut (
    .i_clk  (clock),
    .i_rst  (reset),
    .i_data1(data1),
    .i_data2(data2),
    .i_sel  (sel),
    .i_clr  (clr),
    .i_valid(validIn),
    .o_ready(readyOut),
    .o_suma (suma),
    .o_valid(validOut),
    .i_ready(readyIn),
    .o_ovf  (ovf),
    .o_count(count)
  );

  // Free-running clock, rising edge every 10 time units.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [NB_DATA-1:0] a,
                               input logic [NB_DATA-1:0] b, input logic c, input logic r);
    validIn = v;
    sel     = s;
    data1   = a;
    data2   = b;
    clr     = c;
    readyIn = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " suma"},  32'(suma),     32'd0);
    checkOutput({tag, " valid"}, 32'(validOut), 32'd0);
    checkOutput({tag, " ovf"},   32'(ovf),      32'd0);
    checkOutput({tag, " count"}, 32'(count),    32'd0);
    checkOutput({tag, " ready"}, 32'(readyOut), 32'd1);
  endtask

  // Directed stimulus: reset, table of accepted transactions, then multi-cycle corner cases.
  initial begin
    int expCount;
    checks = 0;
    errors = 0;

    vecs[0]  = '{2'b00, 3'd5, 3'd6, 1'b0, 6'd6,  1'b0};
    vecs[1]  = '{2'b01, 3'd5, 3'd6, 1'b0, 6'd11, 1'b0};
    vecs[2]  = '{2'b10, 3'd5, 3'd6, 1'b0, 6'd5,  1'b0};
    vecs[3]  = '{2'b11, 3'd5, 3'd6, 1'b0, 6'd11, 1'b0};
    vecs[4]  = '{2'b11, 3'd7, 3'd7, 1'b1, 6'd14, 1'b0};
    vecs[5]  = '{2'b11, 3'd7, 3'd7, 1'b0, 6'd28, 1'b0};
    vecs[6]  = '{2'b11, 3'd7, 3'd7, 1'b0, 6'd42, 1'b0};
    vecs[7]  = '{2'b11, 3'd7, 3'd7, 1'b0, 6'd56, 1'b0};
`ifdef ACUMULADOR_SAT_EN
    vecs[8]  = '{2'b11, 3'd7, 3'd7, 1'b0, 6'd63, 1'b1};
    vecs[9]  = '{2'b11, 3'd7, 3'd7, 1'b0, 6'd63, 1'b1};
    vecs[10] = '{2'b11, 3'd7, 3'd7, 1'b0, 6'd63, 1'b1};
    vecs[11] = '{2'b11, 3'd4, 3'd4, 1'b0, 6'd63, 1'b1};
`else
    vecs[8]  = '{2'b11, 3'd7, 3'd7, 1'b0, 6'd6,  1'b1};
    vecs[9]  = '{2'b11, 3'd7, 3'd7, 1'b0, 6'd20, 1'b1};
    vecs[10] = '{2'b11, 3'd7, 3'd7, 1'b0, 6'd34, 1'b1};
    vecs[11] = '{2'b11, 3'd4, 3'd4, 1'b0, 6'd42, 1'b1};
`endif
    vecs[12] = '{2'b11, 3'd2, 3'd3, 1'b1, 6'd5,  1'b0};
    vecs[13] = '{2'b11, 3'd1, 3'd0, 1'b0, 6'd6,  1'b0};
    vecs[14] = '{2'b01, 3'd1, 3'd1, 1'b1, 6'd2,  1'b0};
    vecs[15] = '{2'b11, 3'd0, 3'd1, 1'b0, 6'd1,  1'b0};

    reset = 1'b1;
    applyStimulus(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 1'b1);
    #2;
    checkResetState("reset");
    @(negedge clock);
    reset = 1'b0;

    expCount = 0;
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(1'b1, vecs[i].sel, vecs[i].d1, vecs[i].d2, vecs[i].clr, 1'b1);
      @(posedge clock);
      #1;
      expCount++;
      checkOutput($sformatf("vec%0d suma", i),  32'(suma),     32'(vecs[i].expSuma));
      checkOutput($sformatf("vec%0d valid", i), 32'(validOut), 32'd1);
      checkOutput($sformatf("vec%0d ovf", i),   32'(ovf),      32'(vecs[i].expOvf));
      checkOutput($sformatf("vec%0d count", i), 32'(count),    32'(expCount));
    end

    // Backpressure: result 11 held while downstream stalls, new operands must be ignored.
    applyStimulus(1'b1, 2'b01, 3'd5, 3'd6, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    expCount++;
    checkOutput("bp first suma", 32'(suma), 32'd11);
    applyStimulus(1'b1, 2'b00, 3'd1, 3'd2, 1'b0, 1'b0);
    #1;
    checkOutput("bp ready low", 32'(readyOut), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("bp%0d ready", k), 32'(readyOut), 32'd0);
      checkOutput($sformatf("bp%0d suma", k),  32'(suma),     32'd11);
      checkOutput($sformatf("bp%0d valid", k), 32'(validOut), 32'd1);
      checkOutput($sformatf("bp%0d count", k), 32'(count),    32'(expCount));
    end
    applyStimulus(1'b0, 2'b00, 3'd1, 3'd2, 1'b0, 1'b1);
    #1;
    checkOutput("bp release ready", 32'(readyOut), 32'd1);
    @(posedge clock);
    #1;
    checkOutput("bp handoff valid", 32'(validOut), 32'd0);
    checkOutput("bp handoff suma",  32'(suma),     32'd11);
    checkOutput("bp handoff count", 32'(count),    32'(expCount));

    // Pending, stalled result discarded by an asynchronous mid-cycle reset.
    applyStimulus(1'b1, 2'b10, 3'd5, 3'd6, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    checkOutput("pend suma", 32'(suma), 32'd5);
    applyStimulus(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkResetState("midrst");
    @(negedge clock);
    reset = 1'b0;

    // Counter wrap after 256 accepts.
    applyStimulus(1'b1, 2'b00, 3'd3, 3'd4, 1'b0, 1'b1);
    repeat (255) @(posedge clock);
    #1;
    checkOutput("count 255", 32'(count), 32'd255);
    @(posedge clock);
    #1;
    checkOutput("count wrap", 32'(count), 32'd0);
    checkOutput("wrap suma",  32'(suma),  32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acumulador_selectivo.md
# acumulador_selectivo

Parametrised, registered successor of the selective adder. Each accepted transaction selects one of four operations on two `NB_DATA`-bit operands (pass data2, sum, pass data1, accumulate) and registers an `NB_ACC`-bit result. A running accumulator persists across transactions. The block sits between an operand producer and a result consumer, with valid/ready flow control on both sides.

## Interface
Parameters:
- `NB_DATA`, 3: operand width, ≥1.
- `NB_ACC`, 6: result/accumulator width, ≥ `NB_DATA`+1.

Ports:
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_data1` in `NB_DATA`: operand 1, unsigned.
- `i_data2` in `NB_DATA`: operand 2, unsigned.
- `i_sel` in 2: operation select.
- `i_clr` in 1: clear accumulator; sampled only with an accepted transaction.
- `i_valid` in 1: upstream operands valid.
- `o_ready` out 1: block accepts operands this cycle.
- `o_suma` out `NB_ACC`: registered result.
- `o_valid` out 1: `o_suma` valid.
- `i_ready` in 1: downstream accepts result.
- `o_ovf` out 1: sticky overflow flag.
- `o_count` out 8: accepted-transaction counter.

## Operation
- Accept = `i_valid && o_ready`. Output handoff = `o_valid && i_ready`.
- `o_ready = !o_valid || i_ready`. This is combinational and gives full throughput with no bubble.
- `sum` = `i_data1 + i_data2`, zero-extended to `NB_ACC`. It never overflows.
- Per `i_sel` on accept, with `res` written to `o_suma`:
  - 00: `res = i_data2`.
  - 01: `res = sum`.
  - 10: `res = i_data1`.
  - 11: `res = base + sum`, where `base = i_clr ? 0 : acc`. Then `acc ← res`.
- For `i_sel` ≠ 11, `acc ← i_clr ? 0 : acc`. The accumulator is otherwise unchanged.
- Accumulate overflow (carry out of `NB_ACC`): wraps modulo 2^`NB_ACC` and sets `o_ovf`. `o_ovf` is cleared only by reset or by an accepted transaction with `i_clr=1`. If that same transaction overflows, `o_ovf` = 1.
- `o_count` increments on every accept and wraps 255→0.
- Output register:
  - accept → `o_valid` ← 1 and `o_suma` ← `res`.
  - handoff without accept → `o_valid` ← 0 and `o_suma` holds.
  - `o_suma` is stable while `o_valid && !i_ready`.
- Inputs are ignored when not accepted.

## Timing
- Latency: 1 cycle from accept to `o_valid`. Throughput: 1 result per cycle while `i_ready`=1.
- Reset values: `o_suma`=0, `o_valid`=0, `o_ovf`=0, `o_count`=0, `acc`=0. `o_ready`=1 while in reset and after it.
- Reset asserted mid-operation discards any pending result immediately, with no handoff.
- Back-to-back accumulates: each one uses the `acc` updated by the previous cycle. No forwarding hazard exists.
- Simultaneous accept and handoff in one cycle: the new result replaces the old one, and `o_valid` stays 1.
- Backpressure: with `o_valid`=1 and `i_ready`=0, `o_ready`=0. No state changes.

## Configuration
- `ACUMULADOR_SAT_EN` defined:
  - Accumulate overflow saturates `res` and `acc` to 2^`NB_ACC`−1.
  - `o_ovf` still sets.
  - A saturated accumulator stays at max until cleared.
- `ACUMULADOR_SAT_EN` undefined: wrap-around as described in Operation.

## Structure
- Package `acumulador_pkg` holds:
  - select constants `SEL_DATA2`=2'b00, `SEL_SUMA`=2'b01, `SEL_DATA1`=2'b10, `SEL_ACC`=2'b11.
  - counter width constant `NB_COUNT`=8.
- Sub-module `selector_suma`: combinational unit. It takes the operands, `i_sel`, `base`, and the saturate option, and returns `res` and a carry/overflow bit.
- The top level holds the output register, accumulator, flags, counter and handshake.

## Test plan
Parameters for all scenarios: `NB_DATA`=3, `NB_ACC`=6.
- Reset: assert `i_rst` asynchronously mid-cycle → all outputs 0 at once and `o_ready`=1.
- Mode sweep, each with `i_ready`=1 and `d1`=5, `d2`=6:
  - sel 00 → `o_suma`=6 one cycle after accept.
  - sel 01 → 11.
  - sel 10 → 5.
  - sel 11 from `acc`=0 → 11.
- Accumulate stream: sel 11 with 7+7 per beat, 5 consecutive beats → `o_suma` = 14, 28, 42, 56, then 6 with `o_ovf`=1. With `ACUMULADOR_SAT_EN` defined, the fifth beat gives 63 with `o_ovf`=1.
- Backpressure: hold `i_ready`=0 for 3 cycles after a result of 11 → `o_ready`=0, `o_suma` stays 11, `o_count` is unchanged. Releasing `i_ready` completes the handoff.
- Clear: with `acc`=42 and `o_ovf`=1, send sel 11, `i_clr`=1, 2+3 → `o_suma`=5, `o_ovf`=0, `acc`=5.
- Counter wrap: 256 accepts → `o_count` returns to 0.
